// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register file write-port arbiter: WB priority, LLU result FIFO, pending-write scoreboard
module rf_wb_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_valid,
    input  logic [4:0]  wb_adr,
    input  logic [31:0] wb_data,
    input  logic        llu_issue,
    input  logic [4:0]  llu_issue_adr,
    input  logic        llu_valid,
    output logic        llu_ready,
    input  logic [4:0]  llu_adr,
    input  logic [31:0] llu_data,
    output logic        rf_en,
    output logic [4:0]  rf_w_adr,
    output logic [31:0] rf_w_data,
    output logic [31:0] busy,
    output logic        stall_req,
    output logic        err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [4:0]    mem_adr_q  [DEPTH];
    logic [31:0]   mem_data_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [31:0]   busy_q, busy_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          stall_q, stall_d;
    logic          err_q, err_d;

    logic          wb_eff, empty, full, pop, accept, push;
    logic [4:0]    head_adr;
    logic [31:0]   head_data;
    logic [31:0]   set_vec, clr_vec;

    always_comb begin
        wb_eff    = wb_valid && (wb_adr != 5'd0);
        empty     = (wr_ptr_q == rd_ptr_q);
        full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        head_adr  = mem_adr_q[rd_ptr_q[AW-1:0]];
        head_data = mem_data_q[rd_ptr_q[AW-1:0]];
        pop       = !wb_eff && !empty;
        accept    = llu_valid && !full;
        // results to x0 complete the handshake but never occupy a slot
        push      = accept && (llu_adr != 5'd0);

        rf_en     = 1'b0;
        rf_w_adr  = 5'd0;
        rf_w_data = 32'd0;
        if (wb_eff) begin
            rf_en     = 1'b1;
            rf_w_adr  = wb_adr;
            rf_w_data = wb_data;
        end else if (!empty) begin
            rf_en     = 1'b1;
            rf_w_adr  = head_adr;
            rf_w_data = head_data;
        end

        wr_ptr_d = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop);

        set_vec = 32'd0;
        clr_vec = 32'd0;
        if (llu_issue && (llu_issue_adr != 5'd0)) set_vec[llu_issue_adr] = 1'b1;
        if (pop) clr_vec[head_adr] = 1'b1;
        busy_d = (busy_q & ~clr_vec) | set_vec;

        err_d = err_q;
        if (llu_issue && (llu_issue_adr != 5'd0) && busy_q[llu_issue_adr] &&
            !clr_vec[llu_issue_adr]) err_d = 1'b1;
        if (wb_eff && busy_q[wb_adr]) err_d = 1'b1;
        if (push && !busy_q[llu_adr]) err_d = 1'b1;

        // a non-empty FIFO that does not pop was necessarily blocked by WB
        starve_d = starve_q;
        if (pop || empty) starve_d = '0;
        else if (starve_q < CW'(STARVE_MAX)) starve_d = starve_q + CW'(1);
        stall_d = (starve_d >= CW'(STARVE_MAX));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            busy_q   <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            busy_q   <= busy_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_adr_q[wr_ptr_q[AW-1:0]]  <= llu_adr;
            mem_data_q[wr_ptr_q[AW-1:0]] <= llu_data;
        end
    end

    assign llu_ready = !full;
    assign busy      = busy_q;
    assign stall_req = stall_q;
    assign err       = err_q;
endmodule
